// File: rtl/multi_tick_divider.sv
// multi_tick_divider
//   Shared timebase block. Each of NUM_CH channels divides clk by its own
//   run-time divisor. Each channel produces a one-cycle tick, a square
//   output that toggles on every tick, and a sticky done flag for one-shot
//   use.
//
// Ports
//   clk         system clock
//   reset       asynchronous, active-high reset (divisors return to DEFAULT_DIV)
//   sync_clr    synchronous clear of counters, tick, sq and done (divisors/modes kept)
//   enable      per-channel run enable
//   oneshot     per-channel mode: 0 = periodic, 1 = one-shot
//   load_valid  divisor write strobe (one cycle)
//   load_ch     channel addressed by load_valid; out-of-range values are ignored
//   load_div    divisor value written
//   tick_out    registered one-cycle pulse per period
//   sq_out      registered toggle, inverts on every tick
//   done        sticky flag, set on a one-shot tick
module multi_tick_divider #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 27,
    parameter int DEFAULT_DIV = 50_000_000,
    parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sync_clr,
    input  logic [NUM_CH-1:0] enable,
    input  logic [NUM_CH-1:0] oneshot,
    input  logic              load_valid,
    input  logic [CH_W-1:0]   load_ch,
    input  logic [CNT_W-1:0]  load_div,
    output logic [NUM_CH-1:0] tick_out,
    output logic [NUM_CH-1:0] sq_out,
    output logic [NUM_CH-1:0] done
);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] div_q;
        logic [CNT_W-1:0] eff;
        logic             term;
        logic             load_hit;
        logic             tick_q;
        logic             sq_q;
        logic             done_q;

        // A divisor of 0 behaves like 1 so the counter always has a reachable terminal value.
        assign eff      = (div_q == '0) ? CNT_W'(1) : div_q;
        assign term     = (cnt_q == (eff - CNT_W'(1)));
        // Channel indices beyond NUM_CH never match, so such writes fall on the floor.
        assign load_hit = load_valid && (load_ch == CH_W'(c));

        // ---- channel state register stage ----
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt_q  <= '0;
                div_q  <= CNT_W'(DEFAULT_DIV);
                tick_q <= 1'b0;
                sq_q   <= 1'b0;
                done_q <= 1'b0;
            end else if (sync_clr) begin
                cnt_q  <= '0;
                tick_q <= 1'b0;
                sq_q   <= 1'b0;
                done_q <= 1'b0;
            end else if (load_hit) begin
                // A load wins over a coincident terminal count and restarts the period.
                div_q  <= load_div;
                cnt_q  <= '0;
                tick_q <= 1'b0;
                done_q <= 1'b0;
            end else if (!enable[c]) begin
                tick_q <= 1'b0;
            end else if (oneshot[c] && done_q) begin
                // Halted one-shot: counter already sits at 0 after its tick.
                tick_q <= 1'b0;
            end else if (term) begin
                cnt_q  <= '0;
                tick_q <= 1'b1;
                sq_q   <= ~sq_q;
                if (oneshot[c]) begin
                    done_q <= 1'b1;
                end
            end else begin
                cnt_q  <= cnt_q + CNT_W'(1);
                tick_q <= 1'b0;
            end
        end

        assign tick_out[c] = tick_q;
        assign sq_out[c]   = sq_q;
        assign done[c]     = done_q;
    end

endmodule

// File: tb/tb_multi_tick_divider.sv
// tb_multi_tick_divider
//   Directed bench for multi_tick_divider (NUM_CH=4, CNT_W=8, DEFAULT_DIV=5)
//   plus a NUM_CH=3 instance for out-of-range load decode.
module tb_multi_tick_divider;

    logic       clk = 1'b0;
    logic       reset;
    logic       sync_clr;
    logic [3:0] enable;
    logic [3:0] oneshot;
    logic       load_valid;
    logic [1:0] load_ch;
    logic [7:0] load_div;
    logic [3:0] tick_out;
    logic [3:0] sq_out;
    logic [3:0] done;

    logic [2:0] en3;
    logic [2:0] os3;
    logic       lv3;
    logic [1:0] lch3;
    logic [7:0] ldiv3;
    logic [2:0] tick3;
    logic [2:0] sq3;
    logic [2:0] done3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multi_tick_divider #(
        .NUM_CH(4), .CNT_W(8), .DEFAULT_DIV(5)
    ) u_dut (
        .clk(clk), .reset(reset), .sync_clr(sync_clr),
        .enable(enable), .oneshot(oneshot),
        .load_valid(load_valid), .load_ch(load_ch), .load_div(load_div),
        .tick_out(tick_out), .sq_out(sq_out), .done(done)
    );

    multi_tick_divider #(
        .NUM_CH(3), .CNT_W(8), .DEFAULT_DIV(5)
    ) u_dut3 (
        .clk(clk), .reset(reset), .sync_clr(sync_clr),
        .enable(en3), .oneshot(os3),
        .load_valid(lv3), .load_ch(lch3), .load_div(ldiv3),
        .tick_out(tick3), .sq_out(sq3), .done(done3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        sync_clr = 1'b1;
        step();
        sync_clr = 1'b0;
    endtask

    task automatic do_load(input int ch, input int d);
        load_valid = 1'b1;
        load_ch    = 2'(ch);
        load_div   = 8'(d);
        step();
        load_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++; if (tick_out !== 4'b0) begin errors++; $display("FAIL reset_tick got %b exp 0000", tick_out); end
        checks++; if (sq_out !== 4'b0) begin errors++; $display("FAIL reset_sq got %b exp 0000", sq_out); end
        checks++; if (done !== 4'b0) begin errors++; $display("FAIL reset_done got %b exp 0000", done); end
        checks++; if ({tick3, sq3, done3} !== 9'b0) begin errors++; $display("FAIL reset_dut3 got %b exp 0", {tick3, sq3, done3}); end
        reset = 1'b0;
    endtask

    task automatic test_periodic();
        logic exp_t, exp_s;
        exp_s  = 1'b0;
        enable = 4'b0001;
        for (int k = 1; k <= 15; k++) begin
            step();
            exp_t = (k % 5 == 0);
            if (exp_t) exp_s = ~exp_s;
            checks++; if (tick_out[0] !== exp_t) begin errors++; $display("FAIL periodic_tick k=%0d got %b exp %b", k, tick_out[0], exp_t); end
            checks++; if (sq_out[0] !== exp_s) begin errors++; $display("FAIL periodic_sq k=%0d got %b exp %b", k, sq_out[0], exp_s); end
            checks++; if ({tick_out[3:1], sq_out[3:1]} !== 6'b0) begin errors++; $display("FAIL periodic_others k=%0d got %b exp 0", k, {tick_out[3:1], sq_out[3:1]}); end
        end
    endtask

    task automatic test_oneshot();
        enable  = 4'b0000;
        oneshot = 4'b0000;
        do_clear();
        enable  = 4'b0100;
        oneshot = 4'b0100;
        do_load(2, 3);
        checks++; if ({tick_out[2], done[2]} !== 2'b00) begin errors++; $display("FAIL oneshot_load got %b exp 00", {tick_out[2], done[2]}); end
        for (int k = 1; k <= 8; k++) begin
            step();
            checks++; if (tick_out[2] !== (k == 3)) begin errors++; $display("FAIL oneshot_tick k=%0d got %b exp %b", k, tick_out[2], (k == 3)); end
            checks++; if (done[2] !== (k >= 3)) begin errors++; $display("FAIL oneshot_done k=%0d got %b exp %b", k, done[2], (k >= 3)); end
            checks++; if (sq_out[2] !== (k >= 3)) begin errors++; $display("FAIL oneshot_sq k=%0d got %b exp %b", k, sq_out[2], (k >= 3)); end
        end
        do_load(2, 3);
        checks++; if ({done[2], sq_out[2]} !== 2'b01) begin errors++; $display("FAIL oneshot_reload got %b exp 01", {done[2], sq_out[2]}); end
        for (int k = 1; k <= 5; k++) begin
            step();
            checks++; if (tick_out[2] !== (k == 3)) begin errors++; $display("FAIL reload_tick k=%0d got %b exp %b", k, tick_out[2], (k == 3)); end
            checks++; if (done[2] !== (k >= 3)) begin errors++; $display("FAIL reload_done k=%0d got %b exp %b", k, done[2], (k >= 3)); end
            checks++; if (sq_out[2] !== (k < 3)) begin errors++; $display("FAIL reload_sq k=%0d got %b exp %b", k, sq_out[2], (k < 3)); end
        end
    endtask

    task automatic test_div01();
        logic exp_s;
        enable  = 4'b0000;
        oneshot = 4'b0000;
        do_clear();
        enable = 4'b0010;
        exp_s  = 1'b0;
        for (int d = 0; d <= 1; d++) begin
            do_load(1, d);
            checks++; if ({tick_out[1], sq_out[1]} !== {1'b0, exp_s}) begin errors++; $display("FAIL div%0d_load got %b exp %b", d, {tick_out[1], sq_out[1]}, {1'b0, exp_s}); end
            for (int k = 1; k <= 6; k++) begin
                step();
                exp_s = ~exp_s;
                checks++; if (tick_out[1] !== 1'b1) begin errors++; $display("FAIL div%0d_tick k=%0d got %b exp 1", d, k, tick_out[1]); end
                checks++; if (sq_out[1] !== exp_s) begin errors++; $display("FAIL div%0d_sq k=%0d got %b exp %b", d, k, sq_out[1], exp_s); end
            end
        end
    endtask

    task automatic test_load_override();
        enable  = 4'b0000;
        oneshot = 4'b0000;
        do_clear();
        enable = 4'b0001;
        do_load(0, 5);
        for (int k = 1; k <= 4; k++) begin
            step();
            checks++; if (tick_out[0] !== 1'b0) begin errors++; $display("FAIL ovr_pre k=%0d got %b exp 0", k, tick_out[0]); end
        end
        // counter now sits at its terminal value; the load must suppress the tick
        do_load(0, 7);
        checks++; if (tick_out[0] !== 1'b0) begin errors++; $display("FAIL ovr_load got %b exp 0", tick_out[0]); end
        for (int k = 1; k <= 7; k++) begin
            step();
            checks++; if (tick_out[0] !== (k == 7)) begin errors++; $display("FAIL ovr_tick k=%0d got %b exp %b", k, tick_out[0], (k == 7)); end
        end
        // NUM_CH=3 instance: a write to channel 3 must touch nothing
        en3 = 3'b000;
        do_clear();
        en3   = 3'b111;
        lv3   = 1'b1;
        lch3  = 2'd3;
        ldiv3 = 8'd2;
        step();
        lv3 = 1'b0;
        checks++; if (tick3 !== 3'b000) begin errors++; $display("FAIL oor_first got %b exp 000", tick3); end
        for (int k = 2; k <= 10; k++) begin
            step();
            checks++; if (tick3 !== (((k == 5) || (k == 10)) ? 3'b111 : 3'b000)) begin errors++; $display("FAIL oor_tick k=%0d got %b", k, tick3); end
        end
        en3 = 3'b000;
    endtask

    task automatic test_enable_gate();
        enable  = 4'b0000;
        oneshot = 4'b0000;
        do_clear();
        enable = 4'b0001;
        do_load(0, 5);
        step();
        step();
        enable = 4'b0000;
        for (int k = 1; k <= 10; k++) begin
            step();
            checks++; if ({tick_out[0], sq_out[0]} !== 2'b00) begin errors++; $display("FAIL gate_off k=%0d got %b exp 00", k, {tick_out[0], sq_out[0]}); end
        end
        enable = 4'b0001;
        for (int k = 1; k <= 3; k++) begin
            step();
            checks++; if (tick_out[0] !== (k == 3)) begin errors++; $display("FAIL gate_resume k=%0d got %b exp %b", k, tick_out[0], (k == 3)); end
            checks++; if (sq_out[0] !== (k == 3)) begin errors++; $display("FAIL gate_sq k=%0d got %b exp %b", k, sq_out[0], (k == 3)); end
        end
    endtask

    task automatic test_sync_clr();
        logic [3:0] exp_t;
        enable  = 4'b0000;
        oneshot = 4'b0100;
        do_clear();
        enable = 4'b0101;
        for (int k = 1; k <= 4; k++) begin
            step();
            exp_t = (k == 3) ? 4'b0100 : 4'b0000;
            checks++; if (tick_out !== exp_t) begin errors++; $display("FAIL clr_pre k=%0d got %b exp %b", k, tick_out, exp_t); end
            checks++; if (done[2] !== (k >= 3)) begin errors++; $display("FAIL clr_pre_done k=%0d got %b exp %b", k, done[2], (k >= 3)); end
        end
        do_clear();
        checks++; if ({tick_out, sq_out, done} !== 12'b0) begin errors++; $display("FAIL clr_state got %b exp 0", {tick_out, sq_out, done}); end
        for (int k = 1; k <= 5; k++) begin
            step();
            exp_t = (k == 3) ? 4'b0100 : ((k == 5) ? 4'b0001 : 4'b0000);
            checks++; if (tick_out !== exp_t) begin errors++; $display("FAIL clr_post k=%0d got %b exp %b", k, tick_out, exp_t); end
        end
        checks++; if ({sq_out, done} !== 8'b0101_0100) begin errors++; $display("FAIL clr_final got %b exp 01010100", {sq_out, done}); end
    endtask

    task automatic test_async_reset();
        enable  = 4'b0000;
        oneshot = 4'b0000;
        do_clear();
        enable = 4'b0001;
        do_load(0, 1);
        step();
        step();
        checks++; if (tick_out[0] !== 1'b1) begin errors++; $display("FAIL areset_pre got %b exp 1", tick_out[0]); end
        #3;
        reset = 1'b1;
        #1;
        checks++; if ({tick_out, sq_out, done} !== 12'b0) begin errors++; $display("FAIL areset_now got %b exp 0", {tick_out, sq_out, done}); end
        step();
        reset = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step();
            checks++; if (tick_out[0] !== (k == 5)) begin errors++; $display("FAIL areset_div k=%0d got %b exp %b", k, tick_out[0], (k == 5)); end
        end
    endtask

    initial begin
        reset      = 1'b1;
        sync_clr   = 1'b0;
        enable     = 4'b0000;
        oneshot    = 4'b0000;
        load_valid = 1'b0;
        load_ch    = 2'd0;
        load_div   = 8'd0;
        en3        = 3'b000;
        os3        = 3'b000;
        lv3        = 1'b0;
        lch3       = 2'd0;
        ldiv3      = 8'd0;

        test_reset();
        test_periodic();
        test_oneshot();
        test_div01();
        test_load_override();
        test_enable_gate();
        test_sync_clr();
        test_async_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
